// File: rtl/ctrlport_cmd_master.sv
// Command-stream to CtrlPort master: issues one read/write request at a time
// and returns the responder's status/data (or a timeout) on a response stream.
module ctrlport_cmd_master #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        ctrlport_clk,
    input  logic        ctrlport_rst_n,
    input  logic [52:0] s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    output logic        m_ctrlport_req_wr,
    output logic        m_ctrlport_req_rd,
    output logic [19:0] m_ctrlport_req_addr,
    output logic [31:0] m_ctrlport_req_data,
    input  logic        m_ctrlport_resp_ack,
    input  logic [1:0]  m_ctrlport_resp_status,
    input  logic [31:0] m_ctrlport_resp_data,
    output logic [34:0] m_rsp_tdata,
    output logic        m_rsp_tvalid,
    input  logic        m_rsp_tready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RSP
    } state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    state_t      state;
    logic        is_wr;
    logic [15:0] count;
    logic        strobe;

    assign strobe       = m_ctrlport_req_wr | m_ctrlport_req_rd;
    assign s_cmd_tready = (state == IDLE);
    assign busy         = (state != IDLE);

    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            state               <= IDLE;
            is_wr               <= 1'b0;
            count               <= 16'h0;
            m_ctrlport_req_wr   <= 1'b0;
            m_ctrlport_req_rd   <= 1'b0;
            m_ctrlport_req_addr <= 20'h0;
            m_ctrlport_req_data <= 32'h0;
            m_rsp_tdata         <= 35'h0;
            m_rsp_tvalid        <= 1'b0;
        end else begin
            m_ctrlport_req_wr <= 1'b0;
            m_ctrlport_req_rd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_cmd_tvalid) begin
                        is_wr               <= s_cmd_tdata[52];
                        m_ctrlport_req_wr   <= s_cmd_tdata[52];
                        m_ctrlport_req_rd   <= !s_cmd_tdata[52];
                        m_ctrlport_req_addr <= s_cmd_tdata[51:32];
                        m_ctrlport_req_data <= s_cmd_tdata[31:0];
                        count               <= 16'h0;
                        state               <= WAIT;
                    end
                end
                WAIT: begin
                    // The strobe cycle itself never sees an ack or counts.
                    if (!strobe) begin
                        if (m_ctrlport_resp_ack) begin
                            m_rsp_tdata  <= {1'b0, m_ctrlport_resp_status,
                                             is_wr ? 32'h0 : m_ctrlport_resp_data};
                            m_rsp_tvalid <= 1'b1;
                            state        <= RSP;
                        end else if (count == LIMIT) begin
                            m_rsp_tdata  <= {1'b1, 2'b01, 32'h0};
                            m_rsp_tvalid <= 1'b1;
                            state        <= RSP;
                        end else begin
                            count <= count + 16'h1;
                        end
                    end
                end
                RSP: begin
                    if (m_rsp_tready) begin
                        m_rsp_tvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrlport_cmd_master.sv
// Directed bench for ctrlport_cmd_master: vector table of transactions plus
// hand sequences for backpressure and reset in the middle of a wait.
module tb_ctrlport_cmd_master;

    typedef struct {
        logic        is_wr;
        logic [19:0] addr;
        logic [31:0] data;
        int          ack_at;
        logic        ack_strobe;
        logic [1:0]  st;
        logic [31:0] rdata;
        int          hold;
        int          lat;
        logic [34:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [52:0] s_cmd_tdata = '0;
    logic        s_cmd_tvalid = 1'b0;
    logic        s_cmd_tready;
    logic        req_wr, req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic        ack = 1'b0;
    logic [1:0]  status = 2'b00;
    logic [31:0] rdata = '0;
    logic [34:0] rsp_tdata;
    logic        rsp_tvalid;
    logic        rsp_tready = 1'b0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic press = 1'b0;
    vec_t vecs[6];
    vec_t v2;

    ctrlport_cmd_master #(.TIMEOUT(8)) dut (
        .ctrlport_clk          (clk),
        .ctrlport_rst_n        (rst_n),
        .s_cmd_tdata           (s_cmd_tdata),
        .s_cmd_tvalid          (s_cmd_tvalid),
        .s_cmd_tready          (s_cmd_tready),
        .m_ctrlport_req_wr     (req_wr),
        .m_ctrlport_req_rd     (req_rd),
        .m_ctrlport_req_addr   (req_addr),
        .m_ctrlport_req_data   (req_data),
        .m_ctrlport_resp_ack   (ack),
        .m_ctrlport_resp_status(status),
        .m_ctrlport_resp_data  (rdata),
        .m_rsp_tdata           (rsp_tdata),
        .m_rsp_tvalid          (rsp_tvalid),
        .m_rsp_tready          (rsp_tready),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts in the strobe cycle (command accepted on the preceding edge).
    task automatic finish_txn(input vec_t v);
        int got;
        got = 0;
        @(negedge clk);
        chk("strobe_wr", 64'(req_wr), 64'(v.is_wr));
        chk("strobe_rd", 64'(req_rd), 64'(!v.is_wr));
        chk("req_addr", 64'(req_addr), 64'(v.addr));
        chk("req_data", 64'(req_data), 64'(v.data));
        chk("busy_wait", 64'({busy, s_cmd_tready}), 64'(2'b10));
        status = v.st;
        rdata  = v.rdata;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1)
                chk("strobe_len", 64'({req_wr, req_rd}), 64'(0));
            if (rsp_tvalid) begin
                got = k;
                break;
            end
            ack = (k == v.ack_at);
        end
        ack = 1'b0;
        chk("rsp_latency", 64'(got), 64'(v.lat));
        chk("rsp_tdata", 64'(rsp_tdata), 64'(v.exp));
        chk("addr_hold", 64'({req_addr, req_data}), 64'({v.addr, v.data}));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            ack    = 1'b1;
            status = ~v.st;
            rdata  = ~v.rdata;
            if (press) begin
                s_cmd_tvalid = 1'b1;
                s_cmd_tdata  = {v2.is_wr, v2.addr, v2.data};
            end
            chk("rsp_hold", 64'({rsp_tvalid, s_cmd_tready, req_wr, req_rd,
                                  rsp_tdata}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, v.exp}));
        end
        @(negedge clk);
        ack        = 1'b0;
        rsp_tready = 1'b1;
        @(posedge clk);
        #1 rsp_tready = 1'b0;
        chk("rsp_done", 64'({busy, rsp_tvalid, s_cmd_tready}), 64'(3'b001));
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata  = {v.is_wr, v.addr, v.data};
        chk("cmd_ready", 64'(s_cmd_tready), 64'(1));
        @(posedge clk);
        #1 s_cmd_tvalid = 1'b0;
        ack = v.ack_strobe;
        finish_txn(v);
    endtask

    initial begin
        vecs[0] = '{1'b1, 20'h00010, 32'hDEADBEEF, 2, 1'b0, 2'b00,
                    32'h0BAD0BAD, 0, 3, 35'h0_00000000};
        vecs[1] = '{1'b0, 20'h00004, 32'h0, 1, 1'b0, 2'b11,
                    32'h12345678, 2, 2, 35'h3_12345678};
        vecs[2] = '{1'b0, 20'hABCDE, 32'h0, 0, 1'b1, 2'b00,
                    32'h55555555, 1, 10, 35'h5_00000000};
        vecs[3] = '{1'b0, 20'h00100, 32'h1, 9, 1'b0, 2'b10,
                    32'hCAFEF00D, 0, 10, 35'h2_CAFEF00D};
        vecs[4] = '{1'b1, 20'hFFFFF, 32'hFFFFFFFF, 5, 1'b0, 2'b01,
                    32'h87654321, 3, 6, 35'h1_00000000};
        vecs[5] = '{1'b1, 20'h00020, 32'h00000042, 0, 1'b0, 2'b11,
                    32'h0, 0, 10, 35'h5_00000000};
        v2 = '{1'b1, 20'h00BEE, 32'hA5A5A5A5, 1, 1'b0, 2'b00,
               32'h0, 0, 2, 35'h0_00000000};

        #12;
        chk("reset_out", 64'({req_wr, req_rd, req_addr, req_data, rsp_tvalid,
                              busy, s_cmd_tready}), 64'(1));
        chk("reset_rsp", 64'(rsp_tdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i]);

        // Stray acks in IDLE after a timeout change nothing.
        @(negedge clk);
        ack = 1'b1;
        repeat (3) @(negedge clk);
        ack = 1'b0;
        chk("stray_idle", 64'({busy, rsp_tvalid, req_wr, req_rd}), 64'(0));

        // Backpressure: second command offered during the held response.
        vecs[1].hold = 20;
        press = 1'b1;
        run_txn(vecs[1]);
        press = 1'b0;
        @(posedge clk);
        #1 s_cmd_tvalid = 1'b0;
        finish_txn(v2);

        // Reset in the middle of WAIT.
        @(negedge clk);
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata  = {1'b0, 20'h00077, 32'h0};
        @(posedge clk);
        #1 s_cmd_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid", 64'({req_wr, req_rd, req_addr, req_data, rsp_tvalid,
                            busy, s_cmd_tready}), 64'(1));
        chk("rst_mid_rsp", 64'(rsp_tdata), 64'(0));
        @(negedge clk);
        ack          = 1'b1;
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata  = {1'b0, 20'h00055, 32'h0};
        @(negedge clk);
        chk("rst_no_rsp", 64'(rsp_tvalid), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1 s_cmd_tvalid = 1'b0;
        ack = 1'b0;
        chk("rst_ack_ign", 64'(rsp_tvalid), 64'(0));
        finish_txn('{1'b0, 20'h00055, 32'h0, 3, 1'b0, 2'b00, 32'h00C0FFEE,
                     1, 4, 35'h0_00C0FFEE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
